sysid_boot_checker: RTL and testbench

- Downstream consumer of the system-ID slave's control interface.
- Reads the 32-bit system ID (word offset 0) and the build timestamp (word offset 1) after reset or on request.
- Compares both words against build-time expectations and retries on mismatch.
- Gives boot/reset-sequencing logic a registered pass/fail status before the CPU is released.

---
 rtl/sysid_boot_checker.sv | 213 +++++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// Boot-time checker: reads sysid ID/timestamp words, compares, retries, reports.
// Optional sticky failure interrupt enabled by SYSID_BOOT_CHECKER_IRQ_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h56E4_8391,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_RETRIES  = 2,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [3:0]  retry_count
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    ,
    output logic        irq_fail,
    input  logic        irq_clear
`endif
);

    localparam logic [1:0] LAT  = READ_LATENCY[1:0];
    localparam logic [3:0] MAXR = MAX_RETRIES[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CMP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic [31:0] r_cap_id;
    logic [31:0] r_cap_ts;
    logic [3:0]  r_retry;
    logic        r_auto;

    state_t      w_state_n;
    logic [1:0]  w_cnt_n;
    logic        w_addr_n;
    logic        w_busy_n;
    logic        w_done_n;
    logic        w_pass_n;
    logic        w_id_ok_n;
    logic        w_ts_ok_n;
    logic [31:0] w_cap_id_n;
    logic [31:0] w_cap_ts_n;
    logic [3:0]  w_retry_n;
    logic        w_auto_n;
    logic        w_launch;
    logic        w_term;
    logic        w_id_match;
    logic        w_ts_match;

    assign w_term     = (r_cnt == LAT);
    assign w_id_match = (r_cap_id == EXPECTED_ID);
    assign w_ts_match = (r_cap_ts == EXPECTED_TS);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_addr_n   = r_addr;
        w_busy_n   = r_busy;
        w_done_n   = r_done;
        w_pass_n   = r_pass;
        w_id_ok_n  = r_id_ok;
        w_ts_ok_n  = r_ts_ok;
        w_cap_id_n = r_cap_id;
        w_cap_ts_n = r_cap_ts;
        w_retry_n  = r_retry;
        w_auto_n   = r_auto;
        w_launch   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_launch = start || r_auto;
            end
            S_RD_ID: begin
                if (w_term) begin
                    w_cap_id_n = sysid_readdata;
                    w_cnt_n    = 2'd0;
                    w_addr_n   = 1'b1;
                    w_state_n  = S_RD_TS;
                end else begin
                    w_cnt_n = r_cnt + 2'd1;
                end
            end
            S_RD_TS: begin
                if (w_term) begin
                    w_cap_ts_n = sysid_readdata;
                    w_cnt_n    = 2'd0;
                    w_state_n  = S_CMP;
                end else begin
                    w_cnt_n = r_cnt + 2'd1;
                end
            end
            S_CMP: begin
                w_id_ok_n = w_id_match;
                w_ts_ok_n = w_ts_match;
                if (w_id_match && w_ts_match) begin
                    w_pass_n  = 1'b1;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_DONE;
                end else if (r_retry < MAXR) begin
                    w_retry_n = r_retry + 4'd1;
                    w_addr_n  = 1'b0;
                    w_state_n = S_RD_ID;
                end else begin
                    w_pass_n  = 1'b0;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_launch = start;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Common initialisation for a newly accepted check
        if (w_launch) begin
            w_state_n = S_RD_ID;
            w_cnt_n   = 2'd0;
            w_addr_n  = 1'b0;
            w_busy_n  = 1'b1;
            w_done_n  = 1'b0;
            w_pass_n  = 1'b0;
            w_retry_n = 4'd0;
            w_auto_n  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_addr   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_id_ok  <= 1'b0;
            r_ts_ok  <= 1'b0;
            r_cap_id <= 32'd0;
            r_cap_ts <= 32'd0;
            r_retry  <= 4'd0;
            r_auto   <= AUTO_START;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_addr   <= w_addr_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
            r_pass   <= w_pass_n;
            r_id_ok  <= w_id_ok_n;
            r_ts_ok  <= w_ts_ok_n;
            r_cap_id <= w_cap_id_n;
            r_cap_ts <= w_cap_ts_n;
            r_retry  <= w_retry_n;
            r_auto   <= w_auto_n;
        end
    end

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic r_irq;
    logic w_fail_set;

    assign w_fail_set = (r_state == S_CMP) && (w_state_n == S_DONE) && !w_pass_n;

    // A new failure outranks a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_fail_set) begin
            r_irq <= 1'b1;
        end else if (irq_clear) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_fail = r_irq;
`endif

    assign sysid_address = r_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign id_ok         = r_id_ok;
    assign ts_ok         = r_ts_ok;
    assign captured_id   = r_cap_id;
    assign captured_ts   = r_cap_ts;
    assign retry_count   = r_retry;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: READ_LATENCY 0 and 2 instances run side by side
// against an attempt-level reference model and a latency-modelled sysid slave.
module tb_sysid_boot_checker;

    localparam logic [31:0] EID  = 32'h0000_0000;
    localparam logic [31:0] ETS  = 32'h56E4_8391;
    localparam int          MAXR = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        addr  [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        done  [2];
    logic        pass  [2];
    logic        idok  [2];
    logic        tsok  [2];
    logic [31:0] cid   [2];
    logic [31:0] cts   [2];
    logic [3:0]  rc    [2];
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic        irq   [2];
    logic        irq_clear;
`endif

    logic [31:0] id_v [3];
    logic [31:0] ts_v [3];
    logic        m_irq [2];
    int          cyc = 0;
    int          nchk = 0;
    int          nfail = 0;
    logic        ad1;
    logic        ad2;

    always #5 clock = ~clock;

    sysid_boot_checker #(.READ_LATENCY(0)) u_l0 (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .sysid_address  (addr[0]),
        .sysid_readdata (rdata[0]),
        .busy           (busy[0]),
        .done           (done[0]),
        .pass           (pass[0]),
        .id_ok          (idok[0]),
        .ts_ok          (tsok[0]),
        .captured_id    (cid[0]),
        .captured_ts    (cts[0]),
        .retry_count    (rc[0])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        ,
        .irq_fail       (irq[0]),
        .irq_clear      (irq_clear)
`endif
    );

    sysid_boot_checker #(.READ_LATENCY(2)) u_l2 (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .sysid_address  (addr[1]),
        .sysid_readdata (rdata[1]),
        .busy           (busy[1]),
        .done           (done[1]),
        .pass           (pass[1]),
        .id_ok          (idok[1]),
        .ts_ok          (tsok[1]),
        .captured_id    (cid[1]),
        .captured_ts    (cts[1]),
        .retry_count    (rc[1])
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        ,
        .irq_fail       (irq[1]),
        .irq_clear      (irq_clear)
`endif
    );

    // Slave model: data follows the address 0 or 2 cycles late; the word
    // served depends on which attempt the model says is in progress.
    always @(posedge clock) begin
        ad1 <= addr[1];
        ad2 <= ad1;
    end

    always_comb begin
        int a0;
        int a1;
        a0 = cyc / 3;
        a1 = cyc / 7;
        if (a0 > MAXR) a0 = MAXR;
        if (a1 > MAXR) a1 = MAXR;
        rdata[0] = addr[0] ? ts_v[a0] : id_v[a0];
        rdata[1] = ad2 ? ts_v[a1] : id_v[a1];
    end

    function automatic int lat(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] bad(input logic [31:0] e);
        logic [31:0] v;
        v = $urandom();
        if (v == e) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_good();
        for (int a = 0; a <= MAXR; a++) begin
            id_v[a] = EID;
            ts_v[a] = ETS;
        end
    endtask

    // Runs one check: the first edge is the accept edge (caller has raised
    // start or released reset). Every cycle is compared with the model.
    task automatic run_check(input string tag, input int pulse_at);
        int n;
        int T;
        int L;
        logic ep;
        logic clr;
        logic [7:0] ev;
        logic [7:0] ov;
        logic [65:0] ecap;
        logic [65:0] ocap;
        n = MAXR + 1;
        for (int a = MAXR; a >= 0; a--)
            if (id_v[a] == EID && ts_v[a] == ETS) n = a + 1;
        ep = (id_v[n-1] == EID) && (ts_v[n-1] == ETS);
        cyc = 0;
        for (int c = 0; c <= 22; c++) begin
            clr = 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
            clr = irq_clear;
`endif
            tick();
            cyc = c;
            start = (c == pulse_at);
            for (int k = 0; k < 2; k++) begin
                L = lat(k);
                T = 2 * L + 3;
                if (c < n * T)
                    ev = {1'b1, 1'b0, 1'b0, 4'(c / T), ((c % T) > L)};
                else
                    ev = {1'b0, 1'b1, ep, 4'(n - 1), 1'b1};
                ov = {busy[k], done[k], pass[k], rc[k], addr[k]};
                nchk++;
                if (ov !== ev) begin
                    nfail++;
                    $display("FAIL %s/status inst%0d c=%0d: got %h expected %h",
                             tag, k, c, ov, ev);
                end
                if (c == n * T) begin
                    ecap = {id_v[n-1] == EID, ts_v[n-1] == ETS, id_v[n-1], ts_v[n-1]};
                    ocap = {idok[k], tsok[k], cid[k], cts[k]};
                    nchk++;
                    if (ocap !== ecap) begin
                        nfail++;
                        $display("FAIL %s/capture inst%0d: got %h expected %h",
                                 tag, k, ocap, ecap);
                    end
                end
                if (c == n * T && !ep) m_irq[k] = 1'b1;
                else if (clr) m_irq[k] = 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
                nchk++;
                if (irq[k] !== m_irq[k]) begin
                    nfail++;
                    $display("FAIL %s/irq inst%0d c=%0d: got %b expected %b",
                             tag, k, c, irq[k], m_irq[k]);
                end
`endif
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [73:0] ov;
        reset = 1'b1;
        start = 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        irq_clear = 1'b0;
`endif
        set_good();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 1'b0;
            ov = {addr[k], busy[k], done[k], pass[k], idok[k], tsok[k],
                  cid[k], cts[k], rc[k]};
            nchk++;
            if (ov !== 74'd0) begin
                nfail++;
                $display("FAIL reset_values inst%0d: got %h expected 0", k, ov);
            end
        end
        // start high across the release is irrelevant; auto start governs
        reset = 1'b0;
        start = 1'b1;
        run_check("auto_start", -1);
    endtask

    task automatic test_ts_fail();
        set_good();
        for (int a = 0; a <= MAXR; a++) ts_v[a] = 32'h56E4_8390;
        start = 1'b1;
        run_check("ts_fail", -1);
    endtask

    task automatic test_id_retry();
        set_good();
        id_v[0] = 32'hDEAD_BEEF;
        start = 1'b1;
        run_check("id_retry", -1);
    endtask

    task automatic test_start_while_busy();
        set_good();
        id_v[0] = bad(EID);
        id_v[1] = bad(EID);
        start = 1'b1;
        run_check("busy_start", 5);
    endtask

    task automatic test_mid_reset();
        logic [73:0] ov;
        set_good();
        for (int a = 0; a <= MAXR; a++) ts_v[a] = bad(ETS);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        nchk++;
        if ({addr[0], busy[0]} !== 2'b11) begin
            nfail++;
            $display("FAIL mid_reset/in_rd_ts: got %b expected 11", {addr[0], busy[0]});
        end
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 1'b0;
            ov = {addr[k], busy[k], done[k], pass[k], idok[k], tsok[k],
                  cid[k], cts[k], rc[k]};
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
            ov[73] = ov[73] | irq[k];
`endif
            nchk++;
            if (ov !== 74'd0) begin
                nfail++;
                $display("FAIL mid_reset/zero inst%0d: got %h expected 0", k, ov);
            end
        end
        set_good();
        reset = 1'b0;
        run_check("mid_reset_rerun", -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            for (int a = 0; a <= MAXR; a++) begin
                id_v[a] = ($urandom_range(0, 2) == 0) ? bad(EID) : EID;
                ts_v[a] = ($urandom_range(0, 2) == 0) ? bad(ETS) : ETS;
            end
            start = 1'b1;
            run_check("random", ($urandom_range(0, 1) == 1) ? 1 : -1);
        end
    endtask

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    task automatic test_irq();
        set_good();
        for (int a = 0; a <= MAXR; a++) ts_v[a] = 32'h56E4_8390;
        start = 1'b1;
        run_check("irq_set", -1);
        set_good();
        start = 1'b1;
        run_check("irq_sticky", -1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 1'b0;
            nchk++;
            if (irq[k] !== 1'b0) begin
                nfail++;
                $display("FAIL irq_clear inst%0d: got %b expected 0", k, irq[k]);
            end
        end
        for (int a = 0; a <= MAXR; a++) ts_v[a] = bad(ETS);
        irq_clear = 1'b1;
        start = 1'b1;
        run_check("irq_set_wins", -1);
        irq_clear = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ts_fail();
        test_id_retry();
        test_start_while_busy();
        test_mid_reset();
        test_random();
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
